// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
//
// Shared definitions for the data-memory responder:
//   - default geometry (word-address width, data width, counter width)
//   - host-port FSM state encoding
//   - decoded core-request type and the decode helper used by the top
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

    localparam int DMR_AW    = 7;   // word-address width, depth = 2**AW
    localparam int DMR_DW    = 32;  // data width
    localparam int DMR_CNT_W = 16;  // access-counter width

    // Host FSM. Encoded as a 1-bit enum so the state register is a single flop.
    typedef enum logic {
        HST_IDLE = 1'b0,
        HST_ACK  = 1'b1
    } hst_state_t;

    // Decoded core request. At most one field is set in any cycle.
    typedef struct packed {
        logic rd;   // valid read:  CEN=0, OEN=0, WEN=1
        logic wr;   // valid write: CEN=0, WEN=0, OEN=1
        logic err;  // illegal:     CEN=0, WEN=0, OEN=0
    } core_op_t;

    // All core strobes are active-low. CEN=0 with WEN=1 and OEN=1 is a
    // harmless no-op and decodes to all-zero.
    function automatic core_op_t decode_core(input logic cen,
                                             input logic wen,
                                             input logic oen);
        core_op_t op;
        op.rd  = !cen && !oen &&  wen;
        op.wr  = !cen && !wen &&  oen;
        op.err = !cen && !wen && !oen;
        return op;
    endfunction

endpackage

// File: rtl/data_mem_responder_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// W-bit up-counter that increments by one on each rising edge where inc=1 and
// holds once it reaches all-ones.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, clears count
//   inc    in   increment enable
//   count  out  current count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the core's data-memory port. Holds a 2**AW x DW
// word store. Core reads are combinational (same-cycle ReadDataMem); core
// writes land on the rising edge. A host port can preload or dump words while
// the core leaves the bus idle (CEN=1); the core always has priority.
// Saturating read/write counters and a sticky protocol-error flag are exposed
// for bench checking.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   CEN, WEN, OEN       core strobes, all active-low
//   A, Data2Mem         core word address and write data
//   ReadDataMem         core read data, zero unless a valid read is presented
//   host_req, host_we   host request (held until host_ack), 1=write 0=read
//   host_addr           host word address
//   host_wdata          host write data
//   host_ack            one-cycle completion pulse
//   host_rdata          host read data, held until the next host read
//   rd_cnt, wr_cnt      saturating counts of valid core reads / writes
//   proto_err           sticky: set by CEN=WEN=OEN=0 at an edge
// -----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int AW    = DMR_AW,
    parameter int DW    = DMR_DW,
    parameter int CNT_W = DMR_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    // core data-memory port
    input  logic             CEN,
    input  logic             WEN,
    input  logic             OEN,
    input  logic [AW-1:0]    A,
    input  logic [DW-1:0]    Data2Mem,
    output logic [DW-1:0]    ReadDataMem,
    // host preload / dump port
    input  logic             host_req,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [DW-1:0]    host_wdata,
    output logic             host_ack,
    output logic [DW-1:0]    host_rdata,
    // status
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic             proto_err
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    hst_state_t    state;
    core_op_t      core_op;
    logic          host_go;

    assign core_op = decode_core(CEN, WEN, OEN);

    // A host access only fires from IDLE while the core is deselected, so a
    // host write can never collide with a core write on the same edge.
    assign host_go = (state == HST_IDLE) && host_req && CEN;

    // -------------------------------------------------------------------------
    // Core read mux
    // -------------------------------------------------------------------------
    // NOTE: the output is defaulted before the conditional so every path
    // assigns it and no latch is inferred.
    always_comb begin
        ReadDataMem = '0;
        if (core_op.rd) begin
            ReadDataMem = mem[A];
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array is cleared by reset because software relies on reading
    // zeros after reset; that forces it into flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (core_op.wr) begin
            mem[A] <= Data2Mem;
        end else if (host_go && host_we) begin
            mem[host_addr] <= host_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Host FSM: IDLE performs the access, ACK emits the pulse and always
    // returns to IDLE, so a held request restarts no earlier than the next edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HST_IDLE;
            host_rdata <= '0;
        end else if (state == HST_ACK) begin
            state <= HST_IDLE;
        end else if (host_go) begin
            state <= HST_ACK;
            if (!host_we) begin
                host_rdata <= mem[host_addr];
            end
        end
    end

    assign host_ack = (state == HST_ACK);

    // -------------------------------------------------------------------------
    // Status
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (core_op.err) begin
            proto_err <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (core_op.rd),
        .count (rd_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (core_op.wr),
        .count (wr_cnt)
    );

endmodule
